wb_port_arbiter: RTL

- Shares the two register-file write ports (inst0_wb / inst1_wb, feeding the Operands stage regfile) between N_REQ execution-unit writeback requesters (ALU0, ALU1, MUL/DIV, LSU).
- Grants up to two requests per cycle in round-robin order with a valid/ready handshake.
- Never issues two writes to the same rd in one cycle.
- Drives registered write-port outputs one cycle after the grant.

---
 rtl/wb_port_arbiter_if.sv | 50 +++++
 rtl/wb_port_arbiter.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/wb_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// wb_port_arbiter_if
// Bundles the writeback request handshake and the two register-file write
// ports used by wb_port_arbiter.
//
//   req_valid_i  [N_REQ]         per-requester writeback request
//   req_rd_i     [N_REQ*5]       destination register, requester k at [5k+4:5k]
//   req_value_i  [N_REQ*DATA_W]  writeback data, requester k at slice k
//   req_sid_i    [N_REQ*SID_W]   scoreboard id, requester k at slice k
//   req_ready_o  [N_REQ]         combinational accept (transfer = valid & ready)
//   inst0_wb_*   write port 0 (valid/rd/value/sid), registered
//   inst1_wb_*   write port 1 (valid/rd/value/sid), registered
//
// Modports: slave = arbiter side, master = requester / regfile side.
// -----------------------------------------------------------------------------
interface wb_port_arbiter_if #(
   parameter int N_REQ  = 4,
   parameter int DATA_W = 64,
   parameter int SID_W  = 4
);
   logic [N_REQ-1:0]        req_valid_i;
   logic [N_REQ*5-1:0]      req_rd_i;
   logic [N_REQ*DATA_W-1:0] req_value_i;
   logic [N_REQ*SID_W-1:0]  req_sid_i;
   logic [N_REQ-1:0]        req_ready_o;

   logic                    inst0_wb_valid_o;
   logic [4:0]              inst0_wb_rd_o;
   logic [DATA_W-1:0]       inst0_wb_value_o;
   logic [SID_W-1:0]        inst0_wb_sid_o;

   logic                    inst1_wb_valid_o;
   logic [4:0]              inst1_wb_rd_o;
   logic [DATA_W-1:0]       inst1_wb_value_o;
   logic [SID_W-1:0]        inst1_wb_sid_o;

   modport slave (
      input  req_valid_i, req_rd_i, req_value_i, req_sid_i,
      output req_ready_o,
      output inst0_wb_valid_o, inst0_wb_rd_o, inst0_wb_value_o, inst0_wb_sid_o,
      output inst1_wb_valid_o, inst1_wb_rd_o, inst1_wb_value_o, inst1_wb_sid_o
   );

   modport master (
      output req_valid_i, req_rd_i, req_value_i, req_sid_i,
      input  req_ready_o,
      input  inst0_wb_valid_o, inst0_wb_rd_o, inst0_wb_value_o, inst0_wb_sid_o,
      input  inst1_wb_valid_o, inst1_wb_rd_o, inst1_wb_value_o, inst1_wb_sid_o
   );
endinterface

// File: rtl/wb_port_arbiter.sv
// -----------------------------------------------------------------------------
// wb_port_arbiter
// Shares the two register-file write ports between N_REQ writeback
// requesters. Up to two requests are granted per cycle in round-robin order,
// never two writes to the same rd; writes to x0 are accepted without using a
// port. Granted writes appear on the registered port outputs one cycle later.
//
// Ports:
//   clk       in   clock, rising edge
//   rst       in   asynchronous, active-high reset
//   io_wb     slave modport of wb_port_arbiter_if (requests + write ports)
//   rr_ptr_o  out  current round-robin start index
// -----------------------------------------------------------------------------
module wb_port_arbiter #(
   parameter int N_REQ  = 4,
   parameter int DATA_W = 64,
   parameter int SID_W  = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   wb_port_arbiter_if.slave           io_wb,
   output logic [$clog2(N_REQ)-1:0]   rr_ptr_o
);

   localparam int PTR_W = $clog2(N_REQ);

   // Index of the i-th requester visited when the scan starts at base.
   function automatic logic [PTR_W-1:0] scan_idx(input logic [PTR_W-1:0] base,
                                                 input int offset);
      int sum;
      sum = int'(base) + offset;
      if (sum >= N_REQ) sum = sum - N_REQ;
      return PTR_W'(sum);
   endfunction

   // Successor of idx, wrapping at N_REQ (which need not be a power of two).
   function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] idx);
      return (int'(idx) == N_REQ - 1) ? '0 : PTR_W'(int'(idx) + 1);
   endfunction

   // Per-requester views of the packed request buses
   logic [4:0]        w_req_rd    [N_REQ];
   logic [DATA_W-1:0] w_req_value [N_REQ];
   logic [SID_W-1:0]  w_req_sid   [N_REQ];

   always_comb begin
      for (int k = 0; k < N_REQ; k++) begin
         w_req_rd[k]    = io_wb.req_rd_i[5*k +: 5];
         w_req_value[k] = io_wb.req_value_i[DATA_W*k +: DATA_W];
         w_req_sid[k]   = io_wb.req_sid_i[SID_W*k +: SID_W];
      end
   end

   logic [PTR_W-1:0]  r_rr_ptr;
   logic [N_REQ-1:0]  w_ready;
   logic              w_p0_hit;
   logic [PTR_W-1:0]  w_p0_idx;
   logic              w_p1_hit;
   logic [PTR_W-1:0]  w_p1_idx;
   logic [PTR_W-1:0]  w_idx;

   // Round-robin scan: x0 writes are simply accepted, the first real write
   // takes port 0, the next one with a different rd takes port 1.
   always_comb begin
      // NOTE: every signal gets a default before any conditional assignment,
      // otherwise a path that skips the assignment would infer a latch.
      w_ready  = '0;
      w_p0_hit = 1'b0;
      w_p0_idx = '0;
      w_p1_hit = 1'b0;
      w_p1_idx = '0;
      w_idx    = '0;
      // ready must stay low during reset, so the whole scan is gated by rst
      if (!rst) begin
         for (int i = 0; i < N_REQ; i++) begin
            w_idx = scan_idx(r_rr_ptr, i);
            if (io_wb.req_valid_i[w_idx]) begin
               if (w_req_rd[w_idx] == 5'd0) begin
                  w_ready[w_idx] = 1'b1;
               end else if (!w_p0_hit) begin
                  w_p0_hit       = 1'b1;
                  w_p0_idx       = w_idx;
                  w_ready[w_idx] = 1'b1;
               end else if (!w_p1_hit && (w_req_rd[w_idx] != w_req_rd[w_p0_idx])) begin
                  // same-rd candidates are skipped and retry next cycle
                  w_p1_hit       = 1'b1;
                  w_p1_idx       = w_idx;
                  w_ready[w_idx] = 1'b1;
               end
            end
         end
      end
   end

   assign io_wb.req_ready_o = w_ready;

   logic              r_wb0_valid;
   logic [4:0]        r_wb0_rd;
   logic [DATA_W-1:0] r_wb0_value;
   logic [SID_W-1:0]  r_wb0_sid;
   logic              r_wb1_valid;
   logic [4:0]        r_wb1_rd;
   logic [DATA_W-1:0] r_wb1_value;
   logic [SID_W-1:0]  r_wb1_sid;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // an in-flight write is dropped along with everything else
         r_rr_ptr    <= '0;
         r_wb0_valid <= 1'b0;
         r_wb0_rd    <= '0;
         r_wb0_value <= '0;
         r_wb0_sid   <= '0;
         r_wb1_valid <= 1'b0;
         r_wb1_rd    <= '0;
         r_wb1_value <= '0;
         r_wb1_sid   <= '0;
      end else begin
         r_wb0_valid <= w_p0_hit;
         r_wb1_valid <= w_p1_hit;
         // data fields keep their last values when no write is issued
         if (w_p0_hit) begin
            r_wb0_rd    <= w_req_rd[w_p0_idx];
            r_wb0_value <= w_req_value[w_p0_idx];
            r_wb0_sid   <= w_req_sid[w_p0_idx];
         end
         if (w_p1_hit) begin
            r_wb1_rd    <= w_req_rd[w_p1_idx];
            r_wb1_value <= w_req_value[w_p1_idx];
            r_wb1_sid   <= w_req_sid[w_p1_idx];
         end
         // restart after the last real grant; x0-only cycles leave it alone
         if (w_p1_hit) begin
            r_rr_ptr <= wrap_inc(w_p1_idx);
         end else if (w_p0_hit) begin
            r_rr_ptr <= wrap_inc(w_p0_idx);
         end
      end
   end

   assign io_wb.inst0_wb_valid_o = r_wb0_valid;
   assign io_wb.inst0_wb_rd_o    = r_wb0_rd;
   assign io_wb.inst0_wb_value_o = r_wb0_value;
   assign io_wb.inst0_wb_sid_o   = r_wb0_sid;
   assign io_wb.inst1_wb_valid_o = r_wb1_valid;
   assign io_wb.inst1_wb_rd_o    = r_wb1_rd;
   assign io_wb.inst1_wb_value_o = r_wb1_value;
   assign io_wb.inst1_wb_sid_o   = r_wb1_sid;
   assign rr_ptr_o               = r_rr_ptr;

endmodule
